// File: rtl/vc_ring_router_buf.sv
// Multi-VC wormhole input buffer for one ring-NoC node: per-VC FIFO, route FSM, RR eject/down arbiters.
// Optional VC_DATELINE_EN: at DATELINE_NODE, forwarded VC0 flits leave on VC1 to break the ring cycle.
module vc_ring_router_buf #(
  parameter int FLIT_W        = 48,
  parameter int NODE_W        = 2,
  parameter int NUM_VC        = 2,
  parameter int DEPTH         = 4,
  parameter int DATELINE_NODE = 0,
  localparam int VC_W         = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NODE_W-1:0] current_node,
  input  logic              sel,
  input  logic              ni_valid,
  input  logic [VC_W-1:0]   ni_vc,
  input  logic [FLIT_W-1:0] ni_flit,
  input  logic              up_valid,
  input  logic [VC_W-1:0]   up_vc,
  input  logic [FLIT_W-1:0] up_flit,
  output logic [NUM_VC-1:0] vc_full,
  input  logic [NUM_VC-1:0] down_pause,
  output logic              down_valid,
  output logic [VC_W-1:0]   down_vc,
  output logic [FLIT_W-1:0] down_flit,
  input  logic              ni_ready,
  output logic              eject_valid,
  output logic [VC_W-1:0]   eject_vc,
  output logic [FLIT_W-1:0] eject_flit,
  output logic              err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {R_IDLE, R_EJECT, R_FWD} route_t;

  logic [FLIT_W-1:0] mem [NUM_VC][DEPTH];
  logic [PTR_W-1:0]  wr_ptr [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr [NUM_VC];
  logic [CNT_W-1:0]  count  [NUM_VC];
  logic [CNT_W-1:0]  count_d [NUM_VC];
  logic [FLIT_W-1:0] head_flit [NUM_VC];
  route_t            route_q [NUM_VC];
  route_t            route_d [NUM_VC];
  route_t            route_eff [NUM_VC];
  logic [NUM_VC-1:0] wr_ok, pop, stray, ej_req, dn_req;
  logic              wr_drop;
  logic [VC_W-1:0]   ej_rr, dn_rr, ej_gnt, dn_gnt;
  logic              ej_vld, dn_vld;

  logic              wr_en;
  logic [VC_W-1:0]   wr_vc;
  logic [FLIT_W-1:0] wr_flit;

  assign wr_en   = sel ? ni_valid : up_valid;
  assign wr_vc   = sel ? ni_vc    : up_vc;
  assign wr_flit = sel ? ni_flit  : up_flit;

  function automatic logic is_head(input logic [FLIT_W-1:0] f);
    return f[FLIT_W-1 -: 6] == 6'b101111;
  endfunction

  function automatic logic is_tail(input logic [FLIT_W-1:0] f);
    return f[FLIT_W-1 -: 8] == 8'hFF;
  endfunction

  // VC a flit from source VC v leaves on; also selects which pause bit gates it.
  function automatic logic [VC_W-1:0] map_vc(input logic [VC_W-1:0] v);
`ifdef VC_DATELINE_EN
    if (current_node == NODE_W'(DATELINE_NODE) && v == '0) return VC_W'(1);
`endif
    return v;
  endfunction

  // Returns {valid, index} of the first requester at or after ptr.
  function automatic logic [VC_W:0] rr_pick(input logic [NUM_VC-1:0] req, input logic [VC_W-1:0] ptr);
    logic [VC_W:0] r;
    r = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      int idx;
      idx = (int'(ptr) + i) % NUM_VC;
      if (!r[VC_W] && req[idx]) r = {1'b1, VC_W'(idx)};
    end
    return r;
  endfunction

  function automatic logic [VC_W-1:0] next_vc(input logic [VC_W-1:0] g);
    return (g == VC_W'(NUM_VC - 1)) ? '0 : g + VC_W'(1);
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    ej_req  = '0;
    dn_req  = '0;
    stray   = '0;
    wr_ok   = '0;
    wr_drop = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      head_flit[v] = mem[v][rd_ptr[v]];
      route_eff[v] = route_q[v];
      // An idle VC routes its HEAD in the same cycle it is seen, saving one edge of latency.
      if (route_q[v] == R_IDLE && count[v] != '0) begin
        if (is_head(head_flit[v]))
          route_eff[v] = (head_flit[v][FLIT_W-7 -: NODE_W] == current_node) ? R_EJECT : R_FWD;
        else
          stray[v] = 1'b1;
      end
      ej_req[v] = ni_ready && count[v] != '0 && route_eff[v] == R_EJECT;
      dn_req[v] = count[v] != '0 && route_eff[v] == R_FWD && !down_pause[map_vc(VC_W'(v))];
      if (wr_en && wr_vc == VC_W'(v)) begin
        wr_ok[v] = count[v] != CNT_W'(DEPTH);
        wr_drop  = count[v] == CNT_W'(DEPTH);
      end
    end
    {ej_vld, ej_gnt} = rr_pick(ej_req, ej_rr);
    {dn_vld, dn_gnt} = rr_pick(dn_req, dn_rr);
    for (int v = 0; v < NUM_VC; v++) begin
      pop[v] = stray[v] || (ej_vld && ej_gnt == VC_W'(v)) || (dn_vld && dn_gnt == VC_W'(v));
      route_d[v] = (pop[v] && is_tail(head_flit[v])) ? R_IDLE : route_eff[v];
      count_d[v] = count[v] + CNT_W'(wr_ok[v]) - CNT_W'(pop[v]);
    end
  end

  // NOTE: flit storage has no reset; emptiness is tracked by the reset pointers and counts.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++)
      if (wr_ok[v]) mem[v][wr_ptr[v]] <= wr_flit;
  end

  // NOTE: all sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr[v]  <= '0;
        rd_ptr[v]  <= '0;
        count[v]   <= '0;
        route_q[v] <= R_IDLE;
      end
      vc_full     <= '0;
      ej_rr       <= '0;
      dn_rr       <= '0;
      eject_valid <= 1'b0;
      eject_vc    <= '0;
      eject_flit  <= '0;
      down_valid  <= 1'b0;
      down_vc     <= '0;
      down_flit   <= '0;
      err         <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (wr_ok[v]) wr_ptr[v] <= wr_ptr[v] + PTR_W'(1);
        if (pop[v])   rd_ptr[v] <= rd_ptr[v] + PTR_W'(1);
        count[v]   <= count_d[v];
        route_q[v] <= route_d[v];
        vc_full[v] <= count_d[v] == CNT_W'(DEPTH);
      end
      err         <= err | wr_drop | (|stray);
      eject_valid <= ej_vld;
      if (ej_vld) begin
        eject_vc   <= ej_gnt;
        eject_flit <= head_flit[ej_gnt];
        ej_rr      <= next_vc(ej_gnt);
      end
      down_valid <= dn_vld;
      if (dn_vld) begin
        down_vc   <= map_vc(dn_gnt);
        down_flit <= head_flit[dn_gnt];
        dn_rr     <= next_vc(dn_gnt);
      end
    end
  end
endmodule

// File: tb/tb_vc_ring_router_buf.sv
// Directed bench for vc_ring_router_buf: table-driven eject stream plus hand sequences for
// backpressure, overflow, stray flits, round-robin forwarding and the dateline VC remap.
module tb_vc_ring_router_buf;
  localparam int FLIT_W = 48;
  localparam int NODE_W = 2;
  localparam int NUM_VC = 2;
  localparam int DEPTH  = 4;

`ifdef VC_DATELINE_EN
  localparam logic EXP_DL_VC = 1'b1;
`else
  localparam logic EXP_DL_VC = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NODE_W-1:0] current_node;
  logic              sel, ni_valid, up_valid, ni_ready;
  logic [0:0]        ni_vc, up_vc, down_vc, eject_vc;
  logic [FLIT_W-1:0] ni_flit, up_flit, down_flit, eject_flit;
  logic [NUM_VC-1:0] vc_full, down_pause;
  logic              down_valid, eject_valid, err;

  vc_ring_router_buf #(
    .FLIT_W(FLIT_W), .NODE_W(NODE_W), .NUM_VC(NUM_VC), .DEPTH(DEPTH), .DATELINE_NODE(2)
  ) dut (
    .clk(clk), .rst(rst), .current_node(current_node), .sel(sel),
    .ni_valid(ni_valid), .ni_vc(ni_vc), .ni_flit(ni_flit),
    .up_valid(up_valid), .up_vc(up_vc), .up_flit(up_flit),
    .vc_full(vc_full), .down_pause(down_pause),
    .down_valid(down_valid), .down_vc(down_vc), .down_flit(down_flit),
    .ni_ready(ni_ready), .eject_valid(eject_valid), .eject_vc(eject_vc),
    .eject_flit(eject_flit), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic              ni_valid;
    logic [FLIT_W-1:0] ni_flit;
    logic              exp_ej_valid;
    logic [FLIT_W-1:0] exp_ej_flit;
  } vec_t;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [FLIT_W-1:0] mk_head(input logic [1:0] d, input logic [39:0] p);
    return {6'b101111, d, p};
  endfunction
  function automatic logic [FLIT_W-1:0] mk_body(input logic [39:0] p);
    return {8'h00, p};
  endfunction
  function automatic logic [FLIT_W-1:0] mk_tail(input logic [39:0] p);
    return {8'hFF, p};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ni_valid = 1'b0;
    up_valid = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle_inputs();
    down_pause = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wr(input logic s, input logic vc, input logic [FLIT_W-1:0] f);
    sel = s;
    if (s) begin ni_valid = 1'b1; ni_vc = vc; ni_flit = f; up_valid = 1'b0; end
    else   begin up_valid = 1'b1; up_vc = vc; up_flit = f; ni_valid = 1'b0; end
  endtask

  vec_t tbl [5];
  logic [FLIT_W-1:0] exp_q [6];
  logic              exp_v [6];

  initial begin
    tbl[0] = '{1'b1, mk_head(2'd1, 40'h11), 1'b0, '0};
    tbl[1] = '{1'b1, mk_body(40'h22),       1'b1, mk_head(2'd1, 40'h11)};
    tbl[2] = '{1'b1, mk_tail(40'h33),       1'b1, mk_body(40'h22)};
    tbl[3] = '{1'b0, '0,                    1'b1, mk_tail(40'h33)};
    tbl[4] = '{1'b0, '0,                    1'b0, mk_tail(40'h33)};

    // Reset held with live traffic on both sources: nothing may be captured.
    rst = 1'b1; current_node = 2'd1; ni_ready = 1'b1; down_pause = '0;
    sel = 1'b1; ni_valid = 1'b1; ni_vc = 1'b0; ni_flit = mk_head(2'd1, 40'hAA);
    up_valid = 1'b1; up_vc = 1'b1; up_flit = mk_head(2'd3, 40'hBB);
    tick(); tick();
    check("rst eject_valid", 64'(eject_valid), 64'd0);
    check("rst down_valid",  64'(down_valid),  64'd0);
    check("rst eject_flit",  64'(eject_flit),  64'd0);
    check("rst down_flit",   64'(down_flit),   64'd0);
    check("rst vc_full",     64'(vc_full),     64'd0);
    check("rst err",         64'(err),         64'd0);
    rst = 1'b0; idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post-rst quiet", 64'({eject_valid, down_valid, err}), 64'd0);
    end

    // Local packet ejected in order, 2-edge latency, nothing downstream.
    sel = 1'b1; ni_vc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ni_valid = tbl[i].ni_valid;
      ni_flit  = tbl[i].ni_flit;
      tick();
      check($sformatf("eject[%0d] valid", i), 64'(eject_valid), 64'(tbl[i].exp_ej_valid));
      check($sformatf("eject[%0d] flit", i),  64'(eject_flit),  64'(tbl[i].exp_ej_flit));
      check($sformatf("eject[%0d] vc", i),    64'(eject_vc),    64'd0);
      check($sformatf("eject[%0d] down", i),  64'(down_valid),  64'd0);
    end

    // Upstream packet on VC1 held by down_pause[1] for 5 cycles, then drained.
    do_reset();
    exp_q[0] = mk_head(2'd3, 40'h100); exp_q[1] = mk_body(40'h101);
    exp_q[2] = mk_body(40'h102);       exp_q[3] = mk_tail(40'h103);
    down_pause = 2'b10;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) wr(1'b0, 1'b1, exp_q[i]); else idle_inputs();
      tick();
      check($sformatf("paused[%0d] down", i), 64'(down_valid), 64'd0);
    end
    check("vc1 full", 64'(vc_full), 64'b10);
    down_pause = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("fwd[%0d] valid", i), 64'(down_valid), 64'd1);
      check($sformatf("fwd[%0d] flit", i),  64'(down_flit),  64'(exp_q[i]));
      check($sformatf("fwd[%0d] vc", i),    64'(down_vc),    64'd1);
    end
    tick();
    check("fwd done", 64'({down_valid, eject_valid, vc_full, err}), 64'd0);

    // Overflow: 5 writes to a blocked VC0, fifth dropped and flagged.
    do_reset();
    down_pause = 2'b01;
    wr(1'b1, 1'b0, mk_head(2'd2, 40'h200)); tick();
    for (int i = 1; i < 4; i++) begin
      wr(1'b1, 1'b0, mk_body(40'(32'h200 + i))); tick();
    end
    check("ovf full after 4", 64'(vc_full), 64'b01);
    check("ovf err before",   64'(err),     64'd0);
    wr(1'b1, 1'b0, mk_body(40'h2FF)); tick();
    idle_inputs();
    check("ovf err after", 64'(err),     64'd1);
    check("ovf still full", 64'(vc_full), 64'b01);
    check("ovf no down",   64'(down_valid), 64'd0);
    down_pause = 2'b00;
    tick();
    check("ovf drain head", 64'(down_flit), 64'(mk_head(2'd2, 40'h200)));
    check("ovf drain full", 64'(vc_full),   64'b00);

    // Stray body flit at an idle VC head: dropped, err set, nothing emitted.
    do_reset();
    wr(1'b1, 1'b1, mk_body(40'h300)); tick();
    idle_inputs();
    check("stray err pre", 64'(err), 64'd0);
    tick();
    check("stray err", 64'(err), 64'd1);
    check("stray quiet", 64'({down_valid, eject_valid}), 64'd0);

    // Two forwarded packets on VC0/VC1 interleave round-robin.
    do_reset();
    down_pause = 2'b11;
    exp_q[0] = mk_head(2'd3, 40'h400); exp_v[0] = 1'b0;
    exp_q[1] = mk_head(2'd0, 40'h410); exp_v[1] = 1'b1;
    exp_q[2] = mk_body(40'h401);       exp_v[2] = 1'b0;
    exp_q[3] = mk_body(40'h411);       exp_v[3] = 1'b1;
    exp_q[4] = mk_tail(40'h402);       exp_v[4] = 1'b0;
    exp_q[5] = mk_tail(40'h412);       exp_v[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr(1'b0, exp_v[i], exp_q[i]); tick();
    end
    idle_inputs();
    check("rr paused", 64'(down_valid), 64'd0);
    down_pause = 2'b00;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("rr[%0d] valid", i), 64'(down_valid), 64'd1);
      check($sformatf("rr[%0d] flit", i),  64'(down_flit),  64'(exp_q[i]));
      check($sformatf("rr[%0d] vc", i),    64'(down_vc),    64'(exp_v[i]));
    end
    tick();
    check("rr done", 64'(down_valid), 64'd0);

    // Dateline node: VC0 packet forwarded, output VC depends on build option.
    do_reset();
    current_node = 2'd2;
    wr(1'b0, 1'b0, mk_head(2'd0, 40'h500)); tick();
    wr(1'b0, 1'b0, mk_tail(40'h501)); tick();
    idle_inputs();
    check("dl head valid", 64'(down_valid), 64'd1);
    check("dl head vc",    64'(down_vc),    64'(EXP_DL_VC));
    tick();
    check("dl tail flit",  64'(down_flit),  64'(mk_tail(40'h501)));
    check("dl tail vc",    64'(down_vc),    64'(EXP_DL_VC));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
